// File: rtl/clkdiv_prog.sv
// clkdiv_prog: programmable glitch-free clock divider producing a
// divided square wave, a period-start strobe and the running phase.
// Ports: clkin, rst_n (async, low), en, div[WIDTH], [sync], clkout,
//        tick, phase[WIDTH].
// Optional: define CLKDIV_SYNC_EN to add the sync phase-align input.
module clkdiv_prog #(
  parameter int WIDTH = 6
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             clkout,
  output logic             tick,
  output logic [WIDTH-1:0] phase
);

  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] nact;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] nxt;
  logic             stopped;
  logic             last;
  logic             start;
  logic             load;

  // A divisor of 1 cannot make a square wave, so it runs as /2.
  assign nact    = (div_act == WIDTH'(1)) ? WIDTH'(2) : div_act;
  assign half    = nact >> 1;
  assign nxt     = phase + WIDTH'(1);
  assign stopped = (div_act == '0);
  assign last    = (phase == nact - WIDTH'(1));
  assign start   = (div != '0);

`ifdef CLKDIV_SYNC_EN
  assign load = stopped | last | sync;
`else
  assign load = stopped | last;
`endif

  // The shadowed divisor is only taken on a load (period boundary),
  // so a new div can never shorten the period in flight.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      div_act <= '0;
      phase   <= '0;
      clkout  <= 1'b0;
      tick    <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
    end else if (load) begin
      div_act <= div;
      phase   <= '0;
      clkout  <= start;
      tick    <= start;
    end else begin
      phase  <= nxt;
      clkout <= (nxt < half);
      tick   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: randomized and directed checks of clkdiv_prog
// against a cycle-level behavioural model kept in the bench.
module tb_clkdiv_prog;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] div;
  logic         sync;
  logic         clkout;
  logic         tick;
  logic [W-1:0] phase;

  int tests = 0;
  int fails = 0;

  clkdiv_prog #(.WIDTH(W)) dut (
    .clkin (clk),
    .rst_n (rst_n),
    .en    (en),
    .div   (div),
`ifdef CLKDIV_SYNC_EN
    .sync  (sync),
`endif
    .clkout(clkout),
    .tick  (tick),
    .phase (phase)
  );

  always #5 clk = ~clk;

  // Model: active divisor and position inside the period.
  int m_n   = 0;
  int m_ph  = 0;
  bit m_tk  = 0;
  bit m_bnd = 0;
  bit m_sy;

  function automatic int eff(int n);
    return (n == 1) ? 2 : n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_ph = 0; m_tk = 0;
    end else if (en) begin
`ifdef CLKDIV_SYNC_EN
      m_sy = sync;
`else
      m_sy = 1'b0;
`endif
      m_bnd = (m_n == 0) || (m_ph == eff(m_n) - 1) || m_sy;
      if (m_bnd) begin
        m_n  = int'(div);
        m_ph = 0;
        m_tk = (div != 0);
      end else begin
        m_ph = m_ph + 1;
        m_tk = 0;
      end
    end else begin
      m_tk = 0;
    end
  end

  function automatic void chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Per-cycle comparison; clkout follows from the half-period rule.
  always @(negedge clk) begin
    chk("m_phase", int'(phase), m_ph);
    chk("m_tick", int'(tick), int'(m_tk));
    chk("m_clkout", int'(clkout),
        int'(m_n != 0 && m_ph < eff(m_n) / 2));
  end

  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (tick) return;
    end
    tests++;
    fails++;
    $display("FAIL tick_timeout: got no tick expected tick within 200");
  endtask

  // Starts on a tick cycle; counts cycles and high cycles to next tick.
  task automatic measure(output int hi, output int per);
    hi  = int'(clkout);
    per = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tick) return;
      per++;
      hi += int'(clkout);
    end
    tests++;
    fails++;
    $display("FAIL period_timeout: got no tick expected tick within 200");
  endtask

  int n, hi, per;

  initial begin
    rst_n = 1'b0; en = 1'b0; div = '0; sync = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_phase", int'(phase), 0);
    chk("rst_clkout", int'(clkout), 0);
    chk("rst_tick", int'(tick), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_tick", int'(tick), 0);

    // div=6: first tick one cycle after sampling, then 1,1,1,0,0,0.
    div = 6; en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      chk("d6_phase", int'(phase), i % 6);
      chk("d6_clkout", int'(clkout), int'(i % 6 < 3));
      chk("d6_tick", int'(tick), int'(i % 6 == 0));
      if (i < 11) @(negedge clk);
    end

    // div=5 and div=1.
    div = 5;
    wait_tick(n);
    measure(hi, per);
    chk("d5_period", per, 5);
    chk("d5_high", hi, 2);
    div = 1;
    wait_tick(n);
    measure(hi, per);
    chk("d1_period", per, 2);
    chk("d1_high", hi, 1);

    // div 4 -> 8 changed at phase 1: no runt period.
    div = 4;
    wait_tick(n);
    wait_tick(n);
    @(negedge clk);
    div = 8;
    wait_tick(n);
    chk("d4_keep_period", n + 1, 4);
    measure(hi, per);
    chk("d8_period", per, 8);
    chk("d8_high", hi, 4);

    // div=0 mid-period: finish, then stop; restart with div=3.
    div = 4;
    wait_tick(n);
    wait_tick(n);
    @(negedge clk);
    div = 0;
    repeat (3) @(negedge clk);
    chk("stop_phase", int'(phase), 0);
    chk("stop_clkout", int'(clkout), 0);
    chk("stop_tick", int'(tick), 0);
    repeat (2) @(negedge clk);
    chk("stop_hold", int'(clkout | tick), 0);
    div = 3;
    @(negedge clk);
    chk("restart_tick", int'(tick), 1);

    // en low for 3 cycles at phase 2 of a /6 period.
    div = 6;
    wait_tick(n);
    wait_tick(n);
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("frozen_phase", int'(phase), 2);
    en = 1'b1;
    wait_tick(n);
    chk("stretch_period", n + 5, 9);

`ifdef CLKDIV_SYNC_EN
    wait_tick(n);
    repeat (3) @(negedge clk);
    chk("pre_sync_phase", int'(phase), 3);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_phase", int'(phase), 0);
    chk("sync_tick", int'(tick), 1);
    chk("sync_clkout", int'(clkout), 1);
`endif

    // Async reset at phase 1: outputs clear before the next edge.
    wait_tick(n);
    @(negedge clk);
    chk("pre_rst_clkout", int'(clkout), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phase", int'(phase), 0);
    chk("arst_clkout", int'(clkout), 0);
    chk("arst_tick", int'(tick), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: div = 0;
          1: div = 1;
          2: div = W'(63);
          default: div = W'($urandom_range(2, 12));
        endcase
      end
      sync = ($urandom_range(0, 31) == 0);
    end
    rst_n = 1'b1;
    sync = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
